cam_line_packer: RTL and testbench
==================================

// Module: cam_line_packer
// PURPOSE
//  Downstream of the camera 8->16-bit pixel assembler, in the camera pixel-clock domain.
//  Captures each complete RGB565 line into a two-entry ping-pong line buffer.
//  Emits each captured line as an 8-bit valid/ready byte packet for the UDP transmit path.
//  Packet = 4-byte header {frame_id[15:0], line_id[15:0]} (MSB first) + pixels, high byte first.
// PARAMETERS
//  LINE_PIXELS  1024  pixels per valid line; any other count is an error line
//  ADDR_W       10    line-buffer address width; 2**ADDR_W >= LINE_PIXELS
// PORTS
//  clk        in   1   camera pixel clock (single clock domain)
//  rst        in   1   asynchronous, active-high reset
//  vsync      in   1   frame sync from sensor; rising edge = new frame
//  pix_de     in   1   pixel strobe: pix_data valid this cycle while in a line
//  pix_href   in   1   line active; line ends on its falling edge
//  pix_data   in   16  RGB565 pixel
//  m_valid    out  1   output byte valid
//  m_ready    in   1   downstream accepts byte when m_valid & m_ready
//  m_data     out  8   output byte
//  m_last     out  1   high on the final pixel byte of a packet
//  frame_id   out  16  current frame number
//  drop_cnt   out  16  lines dropped (overflow or bad length), saturates at 16'hFFFF
// BEHAVIOUR
//  Reset: m_valid=0, m_data=0, m_last=0, frame_id=0, line_id=0, drop_cnt=0; both buffers empty,
//   write and read state machines idle.
//  Write side:
//   - vsync rising edge (registered compare): frame_id+=1 (wraps 16'hFFFF->0), line_id=0,
//     any line being written is discarded without counting a drop.
//   - href rising edge: if a buffer is empty, select it (buf0 preferred) and set wr_addr=0;
//     otherwise the whole line is skipped and drop_cnt+=1.
//   - Each pix_de while writing: store at wr_addr, wr_addr+=1; pixels beyond LINE_PIXELS are
//     not stored and mark the line bad.
//   - href falling edge: if wr_addr==LINE_PIXELS and the line is not bad, mark the buffer full
//     and tag it with the current line_id; otherwise release the buffer and drop_cnt+=1.
//     line_id+=1 on every href falling edge, whether the line is kept, dropped or skipped.
//   - Same-cycle href fall and vsync rise: the line is committed first, then the frame advances.
//  Read side FSM: IDLE -> HDR(4 bytes) -> PIX_HI -> PIX_LO -> (PIX_HI | DONE) -> IDLE.
//   - IDLE: when a buffer is full, select it (oldest first; the buffers alternate) and go to HDR.
//     m_valid rises 2 cycles after the href-fall commit cycle if the FSM was idle.
//   - The buffer read is synchronous and prefetched, so bytes stream at 1/cycle while m_ready=1.
//   - m_data/m_valid/m_last are stable while m_valid & !m_ready; no byte is skipped or repeated.
//   - m_last=1 only on the PIX_LO byte of pixel LINE_PIXELS-1; the header never asserts m_last.
//   - DONE marks the buffer empty 1 cycle after the last handshake. The write side may claim
//     that buffer on the following cycle.
//   - The header carries the frame_id/line_id latched at commit, not the live values.
//  Read and write never use the same buffer simultaneously.
//  vsync does not abort a packet already in the read side.
//  Reset mid-packet: outputs return to reset values immediately; the partial packet is lost.
// TESTING (bench uses LINE_PIXELS=8, ADDR_W=3)
//  1. vsync pulse, then one line of 8 pixels 16'h0101..16'h0808, m_ready=1 ->
//     packet 00 01 00 00 01 01 02 02 .. 08 08; m_last on the 20th byte; frame_id=1.
//  2. Hold m_ready=0 while 3 lines arrive -> lines 0 and 1 are buffered, line 2 is dropped
//     (drop_cnt=1). After release: packets for line_id 0 then 1 only.
//  3. Line of 7 pixels and a line of 9 pixels -> no packets emitted; drop_cnt=2;
//     the next 8-pixel line is sent with line_id=2.
//  4. vsync rising mid-line (4 pixels written) -> no packet, drop_cnt unchanged, frame_id+1;
//     the next line carries line_id=0.
//  5. Toggle m_ready randomly every cycle during a packet -> byte sequence identical to
//     test 1, and m_data is held whenever m_valid=1 and m_ready=0.
//  6. Assert rst mid-packet, then run the test 1 stimulus -> m_valid=0 asynchronously;
//     the first packet after reset has frame_id 1 and line_id 0.

Source files
------------

// File: rtl/cam_line_packer.sv
// Camera line packer: captures complete RGB565 lines into a ping-pong buffer and
// streams each one as a byte packet {frame_id, line_id, pixels} over valid/ready.
module cam_line_packer #(
  parameter int LINE_PIXELS = 1024,
  parameter int ADDR_W      = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        vsync,
  input  logic        pix_de,
  input  logic        pix_href,
  input  logic [15:0] pix_data,
  output logic        m_valid,
  input  logic        m_ready,
  output logic [7:0]  m_data,
  output logic        m_last,
  output logic [15:0] frame_id,
  output logic [15:0] drop_cnt
);

  localparam int CNT_W = ADDR_W + 1;
  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [CNT_W-1:0]  LINE_CNT = CNT_W'(LINE_PIXELS);
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(LINE_PIXELS - 1);

  typedef enum logic [2:0] {RD_IDLE, RD_HDR, RD_PIX_HI, RD_PIX_LO, RD_DONE} rd_state_t;

  logic [15:0] mem [2*DEPTH];

  logic              vsync_q, href_q;
  logic              vs_rise, href_rise, href_fall;
  logic [15:0]       line_id;
  logic              in_line, wr_active, wr_sel, wr_bad;
  logic [CNT_W-1:0]  wr_addr;
  logic [1:0]        buf_full;
  logic              oldest;
  logic [1:0][15:0]  tag_frame, tag_line;
  logic              wr_en, line_good, drop_inc;

  rd_state_t         state_q, state_d;
  logic              rd_sel, start, start_sel, load_pix, hs, rd_release;
  logic [ADDR_W-1:0] rd_addr, pix_idx;
  logic [1:0]        hdr_cnt;
  logic [15:0]       rd_q, pix_cur;

  assign vs_rise   = vsync & ~vsync_q;
  assign href_rise = pix_href & ~href_q;
  assign href_fall = ~pix_href & href_q;

  assign wr_en     = wr_active & pix_href & pix_de & (wr_addr < LINE_CNT);
  assign line_good = wr_active && (wr_addr == LINE_CNT) && !wr_bad;
  // A line is dropped either when no buffer is free at its start or when it ends with a bad length.
  assign drop_inc  = (href_rise & (&buf_full)) | (href_fall & wr_active & ~line_good);

  // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vsync_q   <= 1'b0;
      href_q    <= 1'b0;
      frame_id  <= '0;
      line_id   <= '0;
      drop_cnt  <= '0;
      in_line   <= 1'b0;
      wr_active <= 1'b0;
      wr_sel    <= 1'b0;
      wr_bad    <= 1'b0;
      wr_addr   <= '0;
      buf_full  <= '0;
      oldest    <= 1'b0;
      tag_frame <= '0;
      tag_line  <= '0;
    end else begin
      vsync_q <= vsync;
      href_q  <= pix_href;

      if (rd_release) buf_full[rd_sel] <= 1'b0;

      if (wr_active && pix_href && pix_de) begin
        if (wr_addr < LINE_CNT) wr_addr <= wr_addr + 1'b1;
        else                    wr_bad  <= 1'b1;
      end

      if (href_rise) begin
        in_line <= 1'b1;
        wr_addr <= '0;
        wr_bad  <= 1'b0;
        if (!buf_full[0]) begin
          wr_active <= 1'b1;
          wr_sel    <= 1'b0;
        end else if (!buf_full[1]) begin
          wr_active <= 1'b1;
          wr_sel    <= 1'b1;
        end
      end

      if (href_fall) begin
        in_line   <= 1'b0;
        wr_active <= 1'b0;
        if (line_good) begin
          buf_full[wr_sel]  <= 1'b1;
          tag_frame[wr_sel] <= frame_id;
          tag_line[wr_sel]  <= line_id;
          oldest            <= buf_full[~wr_sel] ? ~wr_sel : wr_sel;
        end
        if (in_line) line_id <= line_id + 1'b1;
      end

      if (drop_inc && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 1'b1;

      // Placed last so a coincident line commit uses the old ids before the frame advances.
      if (vs_rise) begin
        frame_id  <= frame_id + 1'b1;
        line_id   <= '0;
        in_line   <= 1'b0;
        wr_active <= 1'b0;
      end
    end
  end

  // NOTE: the line buffer has no reset; its contents are only read after being written.
  always_ff @(posedge clk) begin
    if (wr_en) mem[{wr_sel, wr_addr[ADDR_W-1:0]}] <= pix_data;
    rd_q <= mem[{rd_sel, rd_addr}];
  end

  assign hs         = m_valid & m_ready;
  assign rd_release = (state_q == RD_DONE);
  assign start_sel  = (&buf_full) ? oldest : buf_full[1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= RD_IDLE;
    else     state_q <= state_d;
  end

  // NOTE: every output of this block is defaulted first, so no path can infer a latch.
  always_comb begin
    state_d  = state_q;
    start    = 1'b0;
    load_pix = 1'b0;
    m_valid  = 1'b0;
    m_data   = 8'h00;
    m_last   = 1'b0;
    case (state_q)
      RD_IDLE: begin
        if (|buf_full) begin
          start   = 1'b1;
          state_d = RD_HDR;
        end
      end
      RD_HDR: begin
        m_valid = 1'b1;
        case (hdr_cnt)
          2'd0:    m_data = tag_frame[rd_sel][15:8];
          2'd1:    m_data = tag_frame[rd_sel][7:0];
          2'd2:    m_data = tag_line[rd_sel][15:8];
          default: m_data = tag_line[rd_sel][7:0];
        endcase
        if (hs && hdr_cnt == 2'd3) begin
          load_pix = 1'b1;
          state_d  = RD_PIX_HI;
        end
      end
      RD_PIX_HI: begin
        m_valid = 1'b1;
        m_data  = pix_cur[15:8];
        if (hs) state_d = RD_PIX_LO;
      end
      RD_PIX_LO: begin
        m_valid = 1'b1;
        m_data  = pix_cur[7:0];
        m_last  = (pix_idx == LAST_IDX);
        if (hs) begin
          if (pix_idx == LAST_IDX) begin
            state_d = RD_DONE;
          end else begin
            load_pix = 1'b1;
            state_d  = RD_PIX_HI;
          end
        end
      end
      RD_DONE: state_d = RD_IDLE;
      default: state_d = RD_IDLE;
    endcase
  end

  // Pixel k is prefetched into rd_q during the header / previous pixel, so bytes never bubble.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_sel  <= 1'b0;
      rd_addr <= '0;
      hdr_cnt <= '0;
      pix_cur <= '0;
      pix_idx <= '0;
    end else begin
      if (start) begin
        rd_sel  <= start_sel;
        rd_addr <= '0;
        hdr_cnt <= '0;
      end
      if (state_q == RD_HDR && hs) hdr_cnt <= hdr_cnt + 1'b1;
      if (load_pix) begin
        pix_cur <= rd_q;
        pix_idx <= rd_addr;
        rd_addr <= rd_addr + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_cam_line_packer.sv
// Bench for cam_line_packer: table-driven line scenarios plus hand-written
// back-pressure, random-ready and mid-packet reset sequences, checked by a byte scoreboard.
module tb_cam_line_packer;

  logic        clk, rst, vsync, pix_de, pix_href, m_ready;
  logic [15:0] pix_data;
  logic        m_valid, m_last;
  logic [7:0]  m_data;
  logic [15:0] frame_id, drop_cnt;

  int vec_cnt = 0;
  int err_cnt = 0;
  int ready_mode = 1;   // 0: low, 1: high, 2: random
  logic [8:0] exp_q[$];

  typedef struct {
    logic        pre_vsync;
    int          npix;
    int          abort_at;
    logic [7:0]  seed;
    logic        exp_pkt;
    logic [15:0] exp_frame;
    logic [15:0] exp_line;
    logic [15:0] exp_drop;
  } vec_t;

  cam_line_packer #(.LINE_PIXELS(8), .ADDR_W(3)) dut (
    .clk(clk), .rst(rst), .vsync(vsync), .pix_de(pix_de), .pix_href(pix_href),
    .pix_data(pix_data), .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .m_last(m_last), .frame_id(frame_id), .drop_cnt(drop_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] pix_val(input logic [7:0] seed, input int k);
    return {seed + 8'(k), 8'(k + 1)};
  endfunction

  task automatic push_packet(input logic [15:0] fr, input logic [15:0] ln, input logic [7:0] seed);
    logic [15:0] p;
    exp_q.push_back({1'b0, fr[15:8]});
    exp_q.push_back({1'b0, fr[7:0]});
    exp_q.push_back({1'b0, ln[15:8]});
    exp_q.push_back({1'b0, ln[7:0]});
    for (int k = 0; k < 8; k++) begin
      p = pix_val(seed, k);
      exp_q.push_back({1'b0, p[15:8]});
      exp_q.push_back({(k == 7), p[7:0]});
    end
  endtask

  task automatic pulse_vsync();
    vsync = 1'b1;
    repeat (2) tick();
    vsync = 1'b0;
    repeat (2) tick();
  endtask

  task automatic send_line(input int npix, input int abort_at, input logic [7:0] seed, input int gap);
    pix_href = 1'b1;
    tick();
    for (int k = 0; k < npix; k++) begin
      pix_de   = 1'b1;
      pix_data = pix_val(seed, k);
      vsync    = (abort_at >= 0) && (k == abort_at || k == abort_at + 1);
      tick();
    end
    pix_de   = 1'b0;
    vsync    = 1'b0;
    pix_href = 1'b0;
    repeat (gap) tick();
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    check("drain_q_size", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (3) tick();
    exp_q.delete();
    rst = 1'b0;
    tick();
  endtask

  // Ready driver: the only process writing m_ready.
  initial begin
    m_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       m_ready = 1'b0;
        1:       m_ready = 1'b1;
        default: m_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Monitor: samples on the falling edge; a byte transfers at the next rising edge.
  initial begin
    logic       prev_stall;
    logic [8:0] prev_byte, exp;
    prev_stall = 1'b0;
    prev_byte  = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          check("hold_valid", 32'(m_valid), 32'd1);
          check("hold_byte", 32'({m_last, m_data}), 32'(prev_byte));
        end
        if (m_valid && m_ready) begin
          if (exp_q.size() == 0) begin
            vec_cnt++;
            err_cnt++;
            $display("FAIL extra_byte: got %h, no byte expected", {m_last, m_data});
          end else begin
            exp = exp_q.pop_front();
            check("pkt_byte", 32'({m_last, m_data}), 32'(exp));
          end
        end
        prev_stall = m_valid && !m_ready;
        prev_byte  = {m_last, m_data};
      end
    end
  end

  initial begin
    vec_t tbl[6];
    int   n;

    rst = 1'b1; vsync = 1'b0; pix_de = 1'b0; pix_href = 1'b0; pix_data = '0;

    tbl[0] = '{1'b1, 8, -1, 8'h01, 1'b1, 16'd1, 16'd0, 16'd0};  // basic line
    tbl[1] = '{1'b1, 7, -1, 8'h40, 1'b0, 16'd2, 16'd0, 16'd1};  // short line
    tbl[2] = '{1'b0, 9, -1, 8'h50, 1'b0, 16'd2, 16'd0, 16'd2};  // long line
    tbl[3] = '{1'b0, 8, -1, 8'h60, 1'b1, 16'd2, 16'd2, 16'd2};  // good line keeps counting ids
    tbl[4] = '{1'b1, 8,  4, 8'h70, 1'b0, 16'd4, 16'd0, 16'd2};  // vsync mid-line
    tbl[5] = '{1'b0, 8, -1, 8'h80, 1'b1, 16'd4, 16'd0, 16'd2};  // line id restarts

    ready_mode = 1;
    do_reset();
    check("rst_m_valid", 32'(m_valid), 32'd0);
    check("rst_m_data", 32'(m_data), 32'd0);
    check("rst_m_last", 32'(m_last), 32'd0);
    check("rst_frame_id", 32'(frame_id), 32'd0);
    check("rst_drop_cnt", 32'(drop_cnt), 32'd0);

    for (int i = 0; i < 6; i++) begin
      if (tbl[i].pre_vsync) pulse_vsync();
      if (tbl[i].exp_pkt) push_packet(tbl[i].exp_frame, tbl[i].exp_line, tbl[i].seed);
      send_line(tbl[i].npix, tbl[i].abort_at, tbl[i].seed, 4);
      wait_drain(200);
      repeat (3) tick();
      check($sformatf("tbl%0d_frame_id", i), 32'(frame_id), 32'(tbl[i].exp_frame));
      check($sformatf("tbl%0d_drop_cnt", i), 32'(drop_cnt), 32'(tbl[i].exp_drop));
      check($sformatf("tbl%0d_idle", i), 32'(m_valid), 32'd0);
    end

    // Back-pressure: two lines buffered, third dropped; commit-to-valid latency of 2.
    ready_mode = 0;
    do_reset();
    pulse_vsync();
    push_packet(16'd1, 16'd0, 8'h10);
    push_packet(16'd1, 16'd1, 8'h20);
    send_line(8, -1, 8'h10, 0);
    tick();
    check("bp_valid_c1", 32'(m_valid), 32'd0);
    tick();
    check("bp_valid_c2", 32'(m_valid), 32'd1);
    repeat (2) tick();
    send_line(8, -1, 8'h20, 3);
    send_line(8, -1, 8'h30, 3);
    check("bp_drop_cnt", 32'(drop_cnt), 32'd1);
    check("bp_stall_valid", 32'(m_valid), 32'd1);
    check("bp_stall_data", 32'(m_data), 32'h00);
    ready_mode = 1;
    wait_drain(300);
    repeat (4) tick();
    check("bp_idle", 32'(m_valid), 32'd0);

    // Random ready on every cycle.
    ready_mode = 2;
    do_reset();
    pulse_vsync();
    push_packet(16'd1, 16'd0, 8'h01);
    send_line(8, -1, 8'h01, 4);
    wait_drain(500);
    ready_mode = 1;
    repeat (4) tick();

    // Asynchronous reset in the middle of a packet, then a clean rerun.
    do_reset();
    pulse_vsync();
    push_packet(16'd1, 16'd0, 8'h01);
    send_line(8, -1, 8'h01, 0);
    n = 0;
    while (exp_q.size() > 12 && n < 50) begin
      tick();
      n++;
    end
    check("mid_pkt_reached", 32'(exp_q.size() <= 12), 32'd1);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("arst_m_valid", 32'(m_valid), 32'd0);
    check("arst_m_data", 32'(m_data), 32'd0);
    check("arst_m_last", 32'(m_last), 32'd0);
    check("arst_frame_id", 32'(frame_id), 32'd0);
    exp_q.delete();
    repeat (2) tick();
    rst = 1'b0;
    tick();
    pulse_vsync();
    push_packet(16'd1, 16'd0, 8'h01);
    send_line(8, -1, 8'h01, 4);
    wait_drain(200);
    check("arst_rerun_frame_id", 32'(frame_id), 32'd1);
    check("arst_rerun_drop_cnt", 32'(drop_cnt), 32'd0);

    repeat (5) tick();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
